// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I front-end definitions (opcodes, reset/bubble words, helpers).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_pkg;

   // opcode field inst[6:2]; the two low bits are always 2'b11 for RV32I
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_IMM    = 5'b00100;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_R      = 5'b01100;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;

   // addi x0,x0,0 -- the pipeline bubble
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // what the front end does on a given clock edge, in priority order
   typedef enum logic [1:0] {
      ACT_ADVANCE  = 2'd0,
      ACT_STALL    = 2'd1,
      ACT_REDIRECT = 2'd2
   } fetch_act_t;

   // saturating 32-bit increment for event counters
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/inst_field_slicer.sv
// inst_field_slicer: splits an RV32I instruction word into its decode fields.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input word.
// Ports: i_inst[31:2] in (inst[1:0] carries no decode information);
//        o_op, o_f3, o_rd, o_rs1, o_rs2, o_f7 out.
module inst_field_slicer (
   input  logic [31:2] i_inst,
   output logic [4:0]  o_op,
   output logic [2:0]  o_f3,
   output logic [4:0]  o_rd,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic [6:0]  o_f7
);

   assign o_op  = i_inst[6:2];
   assign o_rd  = i_inst[11:7];
   assign o_f3  = i_inst[14:12];
   assign o_rs1 = i_inst[19:15];
   assign o_rs2 = i_inst[24:20];
   assign o_f7  = i_inst[31:25];

endmodule

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: F-stage PC, instruction-memory address and D-stage instruction.
// Latency: word at im_addr=A appears on D_inst one cycle later (synchronous IM).
// Backpressure: stall holds F and D (D word replayed from a hold buffer);
//               next_pc_sel redirects and wins over stall, costing one D bubble.
// Ports: clk, rst_n (async active-low); stall, next_pc_sel, jb_target[31:0] from
//        the hazard controller / E stage; im_addr out, im_rdata in; D_pc, D_inst,
//        D_valid and decode fields op/f3/rd/rs1/rs2/f7 out.
// Build option: define FETCH_PERF_CNT_EN to add saturating perf_fetch_cnt,
//               perf_stall_cnt and perf_flush_cnt outputs.
module fetch_decode_stage #(
   parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INST = rv_pkg::NOP_INST
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        next_pc_sel,
   input  logic [31:0] jb_target,
   output logic [31:0] im_addr,
   input  logic [31:0] im_rdata,
   output logic [31:0] D_pc,
   output logic [31:0] D_inst,
   output logic        D_valid,
   output logic [4:0]  op,
   output logic [2:0]  f3,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
`ifdef FETCH_PERF_CNT_EN
   output logic [6:0]  f7,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`else
   output logic [6:0]  f7
`endif
);

   import rv_pkg::*;

   logic [31:0] r_f_pc;
   logic [31:0] r_d_pc;
   logic        r_kill_q;
   logic        r_hold_valid;
   logic [31:0] r_hold_inst;

   logic [31:0] w_d_inst;
   fetch_act_t  w_act;
   logic        w_unused;

   // targets are word aligned; the low bits of jb_target are dropped
   assign w_unused = &{1'b1, jb_target[1:0]};

   // redirect beats stall: the stalled D word is on the wrong path anyway
   always_comb begin
      w_act = ACT_ADVANCE;
      if (next_pc_sel) begin
         w_act = ACT_REDIRECT;
      end else if (stall) begin
         w_act = ACT_STALL;
      end
   end

   // im_rdata only tracks im_addr with one cycle lag, so once a stall has
   // held F for an edge the D word must come from the hold buffer instead
   assign w_d_inst = r_kill_q     ? NOP_INST    :
                     r_hold_valid ? r_hold_inst : im_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_f_pc       <= RESET_PC;
         r_d_pc       <= 32'h0000_0000;
         r_kill_q     <= 1'b1;
         r_hold_valid <= 1'b0;
         r_hold_inst  <= NOP_INST;
      end else begin
         case (w_act)
            ACT_REDIRECT: begin
               r_f_pc       <= {jb_target[31:2], 2'b00};
               r_d_pc       <= r_f_pc;
               // the word fetched at the old F_pc arrives next cycle: kill it
               r_kill_q     <= 1'b1;
               r_hold_valid <= 1'b0;
            end
            ACT_STALL: begin
               // capture only on the first stall edge; later edges would
               // capture im_rdata already advanced to the next word
               if (!r_hold_valid) begin
                  r_hold_inst  <= w_d_inst;
                  r_hold_valid <= 1'b1;
               end
            end
            default: begin
               r_f_pc       <= r_f_pc + 32'd4;
               r_d_pc       <= r_f_pc;
               r_kill_q     <= 1'b0;
               r_hold_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_fetch;
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetch <= 32'h0000_0000;
         r_perf_stall <= 32'h0000_0000;
         r_perf_flush <= 32'h0000_0000;
      end else begin
         case (w_act)
            ACT_REDIRECT: r_perf_flush <= sat_inc32(r_perf_flush);
            ACT_STALL:    r_perf_stall <= sat_inc32(r_perf_stall);
            default: begin
               // only count edges that retire a real word out of D
               if (!r_kill_q) begin
                  r_perf_fetch <= sat_inc32(r_perf_fetch);
               end
            end
         endcase
      end
   end

   assign perf_fetch_cnt = r_perf_fetch;
   assign perf_stall_cnt = r_perf_stall;
   assign perf_flush_cnt = r_perf_flush;
`endif

   assign im_addr = r_f_pc;
   assign D_pc    = r_d_pc;
   assign D_inst  = w_d_inst;
   assign D_valid = ~r_kill_q;

   inst_field_slicer u_slicer (
      .i_inst (w_d_inst[31:2]),
      .o_op   (op),
      .o_f3   (f3),
      .o_rd   (rd),
      .o_rs1  (rs1),
      .o_rs2  (rs2),
      .o_f7   (f7)
   );

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage: directed scoreboard bench for fetch_decode_stage.
// Latency: bench model IM returns mem[im_addr] one clock after the address.
// Backpressure: stall/redirect driven from a directed cycle-by-cycle script.
module tb_fetch_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        next_pc_sel;
   logic [31:0] jb_target;
   logic [31:0] im_addr;
   logic [31:0] im_rdata;
   logic [31:0] D_pc;
   logic [31:0] D_inst;
   logic        D_valid;
   logic [4:0]  op;
   logic [2:0]  f3;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  f7;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   fetch_decode_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .next_pc_sel (next_pc_sel),
      .jb_target   (jb_target),
      .im_addr     (im_addr),
      .im_rdata    (im_rdata),
      .D_pc        (D_pc),
      .D_inst      (D_inst),
      .D_valid     (D_valid),
      .op          (op),
      .f3          (f3),
      .rd          (rd),
      .rs1         (rs1),
      .rs2         (rs2),
`ifdef FETCH_PERF_CNT_EN
      .f7             (f7),
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`else
      .f7          (f7)
`endif
   );

   always #5 clk = ~clk;

   // cycle 0 is the interval between reset release and the first edge
   int cyc = -3;
   always @(posedge clk) cyc <= cyc + 1;

   // instruction memory contents; unlisted words get a recognisable pattern
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0000_0013;
         32'h0000_0004: return 32'h0050_0093;
         32'h0000_0008: return 32'h0020_A023;
         32'h0000_0040: return 32'h02A0_0113;
         32'h0000_0080: return 32'h00C0_0193;
         default:       return 32'hA000_0000 | {4'h0, a[27:0]};
      endcase
   endfunction

   always @(posedge clk) im_rdata <= mem_word(im_addr);

   typedef struct {
      int          cyc;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] addr;
      logic        ck_perf;
      logic [31:0] pf;
      logic [31:0] ps;
      logic [31:0] pfl;
   } exp_t;

   exp_t sb[$];
   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input int c, input logic [31:0] act,
                        input logic [31:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, act, want);
   endtask

   // monitor: compare every expectation due in the current cycle
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] ei;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.cyc < cyc) begin
            n_chk++;
            $display("FAIL late_entry cyc=%0d expected_cyc=%0d", cyc, e.cyc);
         end else begin
            ei = e.inst;
            check("D_valid", e.cyc, {31'd0, D_valid}, {31'd0, e.valid});
            check("D_pc",    e.cyc, D_pc,    e.pc);
            check("D_inst",  e.cyc, D_inst,  ei);
            check("im_addr", e.cyc, im_addr, e.addr);
            check("op",      e.cyc, {27'd0, op},  {27'd0, ei[6:2]});
            check("rd",      e.cyc, {27'd0, rd},  {27'd0, ei[11:7]});
            check("f3",      e.cyc, {29'd0, f3},  {29'd0, ei[14:12]});
            check("rs1",     e.cyc, {27'd0, rs1}, {27'd0, ei[19:15]});
            check("rs2",     e.cyc, {27'd0, rs2}, {27'd0, ei[24:20]});
            check("f7",      e.cyc, {25'd0, f7},  {25'd0, ei[31:25]});
`ifdef FETCH_PERF_CNT_EN
            if (e.ck_perf) begin
               check("perf_fetch", e.cyc, perf_fetch_cnt, e.pf);
               check("perf_stall", e.cyc, perf_stall_cnt, e.ps);
               check("perf_flush", e.cyc, perf_flush_cnt, e.pfl);
            end
`endif
         end
      end
   end

   // advance to 1 time unit after the edge that starts cycle c
   task automatic go(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expq(input int c, input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic [31:0] addr,
                       input logic ckp = 1'b0, input logic [31:0] pf = 32'd0,
                       input logic [31:0] ps = 32'd0, input logic [31:0] pfl = 32'd0);
      exp_t e;
      e.cyc = c; e.valid = v; e.pc = pc; e.inst = inst; e.addr = addr;
      e.ck_perf = ckp; e.pf = pf; e.ps = ps; e.pfl = pfl;
      sb.push_back(e);
   endtask

   initial begin
      #3000;
      $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; stall = 1'b0; next_pc_sel = 1'b0; jb_target = 32'd0;

      // reset release and straight-line fetch
      go(0);  rst_n = 1'b1;
              expq(0,  1'b0, 32'h0,  32'h0000_0013, 32'h0, 1'b1, 32'd0, 32'd0, 32'd0);
      go(1);  expq(1,  1'b1, 32'h0,  32'h0000_0013, 32'h4);
      go(2);  expq(2,  1'b1, 32'h4,  32'h0050_0093, 32'h8);
      // three-cycle stall on the store at 0x8
      go(3);  stall = 1'b1;
              expq(3,  1'b1, 32'h8,  32'h0020_A023, 32'hC);
      go(4);  expq(4,  1'b1, 32'h8,  32'h0020_A023, 32'hC);
      go(5);  expq(5,  1'b1, 32'h8,  32'h0020_A023, 32'hC);
      go(6);  stall = 1'b0;
              expq(6,  1'b1, 32'h8,  32'h0020_A023, 32'hC);
      // redirect to 0x41 -> aligned 0x40
      go(7);  next_pc_sel = 1'b1; jb_target = 32'h41;
              expq(7,  1'b1, 32'hC,  32'hA000_000C, 32'h10);
      go(8);  next_pc_sel = 1'b0;
              expq(8,  1'b0, 32'h10, 32'h0000_0013, 32'h40);
      // stall loads the hold buffer, then redirect+stall together
      go(9);  stall = 1'b1;
              expq(9,  1'b1, 32'h40, 32'h02A0_0113, 32'h44);
      go(10); next_pc_sel = 1'b1; jb_target = 32'h80;
              expq(10, 1'b1, 32'h40, 32'h02A0_0113, 32'h44);
      go(11); next_pc_sel = 1'b0; stall = 1'b0;
              expq(11, 1'b0, 32'h44, 32'h0000_0013, 32'h80);
      // redirect to the top word to exercise PC wrap
      go(12); next_pc_sel = 1'b1; jb_target = 32'hFFFF_FFFF;
              expq(12, 1'b1, 32'h80, 32'h00C0_0193, 32'h84);
      go(13); next_pc_sel = 1'b0;
              expq(13, 1'b0, 32'h84, 32'h0000_0013, 32'hFFFF_FFFC);
      go(14); expq(14, 1'b1, 32'hFFFF_FFFC, 32'hAFFF_FFFC, 32'h0);
      go(15); stall = 1'b1;
              expq(15, 1'b1, 32'h0,  32'h0000_0013, 32'h4, 1'b1, 32'd4, 32'd4, 32'd3);
      // asynchronous reset in the middle of a stall
      go(16); #1 rst_n = 1'b0;
              expq(16, 1'b0, 32'h0,  32'h0000_0013, 32'h0, 1'b1, 32'd0, 32'd0, 32'd0);
      go(17); rst_n = 1'b1; stall = 1'b0;
              expq(17, 1'b0, 32'h0,  32'h0000_0013, 32'h0, 1'b1, 32'd0, 32'd0, 32'd0);
      go(18); expq(18, 1'b1, 32'h0,  32'h0000_0013, 32'h4);
      go(19); expq(19, 1'b1, 32'h4,  32'h0050_0093, 32'h8);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         n_chk++;
         $display("FAIL drain pending=%0d expected=0", sb.size());
      end
      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
